q_matrix_loader: RTL and testbench

Q_MATRIX_LOADER -- requirements
Module: q_matrix_loader

---
 rtl/q_matrix_loader.sv | 138 +++++++++++++
 tb/tb_q_matrix_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/q_matrix_loader.sv
// Row-serial loader for an N x N binary weight matrix with a valid/ack handoff to the consumer.
// Optional build macro QLOAD_SYMM_CHECK_EN adds a CHECK state and a sym_err output flag.
module q_matrix_loader #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_sop,
    input  logic [N-1:0]   row_in,
    output logic [N*N-1:0] Q,
    output logic           q_valid,
    input  logic           q_ack,
`ifdef QLOAD_SYMM_CHECK_EN
    output logic           sym_err,
`endif
    output logic           sop_err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef QLOAD_SYMM_CHECK_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic          xfer;
    logic          frame_end;

    assign xfer = in_valid && in_ready;

    // A frame completes on the sop row when N==1, otherwise on the non-sop row at the last index.
    assign frame_end = xfer && (((state == IDLE) && in_sop && (N == 1)) ||
                                ((state == LOAD) && !in_sop && (cnt == LAST)));

`ifdef QLOAD_SYMM_CHECK_EN
    logic asym_acc;
    logic mismatch;

    function automatic logic [N-1:0] row_of(input logic [N*N-1:0] q, input logic [CW-1:0] idx);
        return q[int'(idx)*N +: N];
    endfunction

    function automatic logic [N-1:0] col_of(input logic [N*N-1:0] q, input logic [CW-1:0] idx);
        logic [N-1:0] c;
        for (int j = 0; j < N; j++) begin
            c[j] = q[j*N + int'(idx)];
        end
        return c;
    endfunction

    assign mismatch = row_of(Q, cnt) != col_of(Q, cnt);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            Q        <= '0;
            q_valid  <= 1'b0;
            in_ready <= 1'b1;
            sop_err  <= 1'b0;
`ifdef QLOAD_SYMM_CHECK_EN
            sym_err  <= 1'b0;
            asym_acc <= 1'b0;
`endif
        end else begin
            sop_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (in_sop) begin
                            Q[N-1:0] <= row_in;
                            cnt      <= (N > 1) ? CW'(1) : '0;
                            state    <= LOAD;
                        end else begin
                            sop_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (in_sop) begin
                            Q[N-1:0] <= row_in;
                            cnt      <= (N > 1) ? CW'(1) : '0;
                        end else begin
                            Q[int'(cnt)*N +: N] <= row_in;
                            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                        end
                    end
                end
`ifdef QLOAD_SYMM_CHECK_EN
                // One row/column pair compared per cycle; cnt doubles as the check index.
                CHECK: begin
                    if (cnt == LAST) begin
                        state    <= DONE;
                        q_valid  <= 1'b1;
                        sym_err  <= asym_acc | mismatch;
                        asym_acc <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        asym_acc <= asym_acc | mismatch;
                        cnt      <= cnt + CW'(1);
                    end
                end
`endif
                DONE: begin
                    if (q_ack) begin
                        state    <= IDLE;
                        q_valid  <= 1'b0;
                        in_ready <= 1'b1;
`ifdef QLOAD_SYMM_CHECK_EN
                        sym_err  <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            if (frame_end) begin
                cnt      <= '0;
                in_ready <= 1'b0;
`ifdef QLOAD_SYMM_CHECK_EN
                state    <= CHECK;
`else
                state    <= DONE;
                q_valid  <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_q_matrix_loader.sv
// Randomized bench for q_matrix_loader against a transaction-level matrix model.
// Handles both builds; define QLOAD_SYMM_CHECK_EN consistently for RTL and bench.
module tb_q_matrix_loader;

    localparam int N = 4;
    localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_DONE = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_sop;
    logic [N-1:0]   row_in;
    logic [N*N-1:0] Q;
    logic           q_valid;
    logic           q_ack;
    logic           sop_err;
`ifdef QLOAD_SYMM_CHECK_EN
    logic           sym_err;
`endif

    always #5 clk = ~clk;

    q_matrix_loader #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sop   (in_sop),
        .row_in   (row_in),
        .Q        (Q),
        .q_valid  (q_valid),
        .q_ack    (q_ack),
`ifdef QLOAD_SYMM_CHECK_EN
        .sym_err  (sym_err),
`endif
        .sop_err  (sop_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: what the consumer should see, tracked per accepted row.
    int           phase;
    int           rows;
    int           chk_left;
    logic [N-1:0] m [N];
    logic         exp_sop_err;
    logic         exp_asym;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*N-1:0] model_q();
        logic [N*N-1:0] v;
        for (int r = 0; r < N; r++) v[r*N +: N] = m[r];
        return v;
    endfunction

    function automatic logic model_asym();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (m[i][j] != m[j][i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        phase = P_IDLE;
        rows = 0;
        chk_left = 0;
        for (int r = 0; r < N; r++) m[r] = '0;
        exp_sop_err = 1'b0;
        exp_asym = 1'b0;
    endtask

    task automatic model_frame_done();
`ifdef QLOAD_SYMM_CHECK_EN
        phase = P_CHECK;
        chk_left = N;
`else
        phase = P_DONE;
        exp_asym = model_asym();
`endif
    endtask

    task automatic model_edge(input logic v, input logic s, input logic [N-1:0] r, input logic a);
        exp_sop_err = 1'b0;
        if (phase == P_DONE) begin
            if (a) begin
                phase = P_IDLE;
                exp_asym = 1'b0;
            end
        end else if (phase == P_CHECK) begin
            chk_left--;
            if (chk_left == 0) begin
                phase = P_DONE;
                exp_asym = model_asym();
            end
        end else if (v) begin
            if (s) begin
                m[0] = r;
                rows = 1;
                if (N == 1) model_frame_done();
                else phase = P_LOAD;
            end else if (phase == P_IDLE) begin
                exp_sop_err = 1'b1;
            end else begin
                m[rows] = r;
                rows++;
                if (rows == N) model_frame_done();
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".q"}, 64'(Q), 64'(model_q()));
        check({tag, ".q_valid"}, 64'(q_valid), 64'(phase == P_DONE));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(phase == P_IDLE || phase == P_LOAD));
        check({tag, ".sop_err"}, 64'(sop_err), 64'(exp_sop_err));
`ifdef QLOAD_SYMM_CHECK_EN
        check({tag, ".sym_err"}, 64'(sym_err), 64'(phase == P_DONE && exp_asym));
`endif
    endtask

    task automatic cyc(input string tag, input logic v, input logic s,
                       input logic [N-1:0] r, input logic a);
        in_valid = v;
        in_sop   = s;
        row_in   = r;
        q_ack    = a;
        @(posedge clk);
        model_edge(v, s, r, a);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) cyc(tag, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic frame(input string tag, input logic [N*N-1:0] mat);
        for (int r = 0; r < N; r++) cyc(tag, 1'b1, r == 0, mat[r*N +: N], 1'b0);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases on a falling edge.
    task automatic async_reset(input string tag);
        in_valid = 1'b0;
        in_sop = 1'b0;
        q_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".rst_q"}, 64'(Q), 64'(0));
        check({tag, ".rst_q_valid"}, 64'(q_valid), 64'(0));
        check({tag, ".rst_sop_err"}, 64'(sop_err), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all({tag, ".release"});
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sop = 1'b0;
        row_in = '0;
        q_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset.q", 64'(Q), 64'(0));
        check("reset.q_valid", 64'(q_valid), 64'(0));
        check("reset.sop_err", 64'(sop_err), 64'(0));
        rst_n = 1'b1;
        idle("post_reset", 1);

        frame("diag", 16'h8421);
        idle("diag_wait", N);
        check("diag.q_const", 64'(Q), 64'h8421);
        for (int k = 0; k < 10; k++) cyc("done_hold", 1'b1, 1'($urandom), N'($urandom), 1'b0);
        cyc("ack", 1'b0, 1'b0, '0, 1'b1);
        idle("after_ack", 1);

        cyc("nosop", 1'b1, 1'b0, 4'hF, 1'b0);
        idle("nosop_clear", 2);

        cyc("restart_a", 1'b1, 1'b1, 4'h5, 1'b0);
        cyc("restart_a", 1'b1, 1'b0, 4'hA, 1'b0);
        frame("restart_b", 16'h3C69);
        idle("restart_wait", N);
        cyc("restart_ack", 1'b0, 1'b0, '0, 1'b1);

        frame("asym", 16'h8423);
        idle("asym_wait", N);
        cyc("asym_ack", 1'b0, 1'b0, '0, 1'b1);

        cyc("midload", 1'b1, 1'b1, 4'h7, 1'b0);
        cyc("midload", 1'b1, 1'b0, 4'hE, 1'b0);
        async_reset("midload");
        frame("reload", 16'h1248);
        idle("reload_wait", N);
        async_reset("in_done");

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) == 0) async_reset("rand");
            cyc("rand", $urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
                N'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
